// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline front-ends, the memory port arbiter and the unified memory.
// master: arbiter view; slave: pipeline/memory view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          if_stall;
    logic [1:0]    d_sig;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          stall_out;
    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    modport master (
        input  if_req, if_addr, d_sig, d_addr, d_wdata, m_rdata,
        output if_rdata, if_ready, if_stall, d_rdata, d_ready, stall_out,
               m_en, m_we, m_addr, m_wdata
    );

    modport slave (
        output if_req, if_addr, d_sig, d_addr, d_wdata, m_rdata,
        input  if_rdata, if_ready, if_stall, d_rdata, d_ready, stall_out,
               m_en, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between instruction fetch and the MEM stage.
// Optional stall performance counters are built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic        clk,
    input  logic        rst,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0] perf_dstall,
    output logic [31:0] perf_istall,
`endif
    mem_port_arbiter_if.master bus
);
    localparam int CW = $clog2(MEM_LAT + 1);

    typedef enum logic [2:0] {IDLE, D_WAIT, I_WAIT, D_DONE, I_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          m_en_q, m_en_d;
    logic          m_we_q, m_we_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic          d_ready_q, d_ready_d;
    logic          if_ready_q, if_ready_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic          stall_w, if_stall_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            m_en_q     <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            d_ready_q  <= 1'b0;
            if_ready_q <= 1'b0;
            d_rdata_q  <= '0;
            if_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            m_en_q     <= m_en_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            d_ready_q  <= d_ready_d;
            if_ready_q <= if_ready_d;
            d_rdata_q  <= d_rdata_d;
            if_rdata_q <= if_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        m_en_d     = 1'b0;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        d_ready_d  = 1'b0;
        if_ready_d = 1'b0;
        d_rdata_d  = d_rdata_q;
        if_rdata_d = if_rdata_q;
        case (state_q)
            IDLE: begin
                // The MEM-stage access belongs to the older instruction, so it wins.
                if (bus.d_sig != 2'b00) begin
                    state_d   = D_WAIT;
                    cnt_d     = CW'(MEM_LAT);
                    m_en_d    = 1'b1;
                    m_we_d    = bus.d_sig[0];
                    m_addr_d  = bus.d_addr;
                    m_wdata_d = bus.d_wdata;
                end else if (bus.if_req) begin
                    state_d  = I_WAIT;
                    cnt_d    = CW'(MEM_LAT);
                    m_en_d   = 1'b1;
                    m_we_d   = 1'b0;
                    m_addr_d = bus.if_addr;
                end
            end
            D_WAIT: begin
                if (cnt_q == '0) begin
                    state_d   = D_DONE;
                    d_ready_d = 1'b1;
                    if (!m_we_q) d_rdata_d = bus.m_rdata;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            I_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = I_DONE;
                    if_ready_d = 1'b1;
                    if_rdata_d = bus.m_rdata;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            // One pulse cycle without arbitration keeps the finished request from re-issuing.
            D_DONE, I_DONE: state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    assign stall_w    = ~rst & (bus.d_sig != 2'b00) & ~d_ready_q;
    assign if_stall_w = stall_w | (~rst & bus.if_req & ~if_ready_q);

    assign bus.stall_out = stall_w;
    assign bus.if_stall  = if_stall_w;
    assign bus.m_en      = m_en_q;
    assign bus.m_we      = m_we_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_rdata  = if_rdata_q;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_dstall_q, perf_dstall_d;
    logic [31:0] perf_istall_q, perf_istall_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_dstall_q <= '0;
            perf_istall_q <= '0;
        end else begin
            perf_dstall_q <= perf_dstall_d;
            perf_istall_q <= perf_istall_d;
        end
    end

    // Saturating counts; fetch-only stalls are those not already caused by the MEM stage.
    always_comb begin
        perf_dstall_d = perf_dstall_q;
        perf_istall_d = perf_istall_q;
        if (stall_w && perf_dstall_q != 32'hFFFF_FFFF)
            perf_dstall_d = perf_dstall_q + 32'd1;
        if (if_stall_w && !stall_w && perf_istall_q != 32'hFFFF_FFFF)
            perf_istall_d = perf_istall_q + 32'd1;
    end

    assign perf_dstall = perf_dstall_q;
    assign perf_istall = perf_istall_q;
`endif
endmodule
